// File: rtl/dense_layer_tm_if.sv
// Handshake and storage-write bundle for the time-multiplexed dense layer.
// The layer itself uses the slave view; the upstream/downstream side uses master.
interface dense_layer_tm_if #(
    parameter int ROWS      = 30,
    parameter int COLS      = 64,
    parameter int DATAWIDTH = 11
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [COLS*DATAWIDTH-1:0]     in_vec;
    logic                          act_mode;

    logic                          wt_we;
    logic [RW-1:0]                 wt_row;
    logic [COLS*DATAWIDTH-1:0]     wt_data;

    logic                          bias_we;
    logic [RW-1:0]                 bias_row;
    logic [2*DATAWIDTH-1:0]        bias_data;
    logic                          bias_accum;

    logic                          out_valid;
    logic                          out_ready;
    logic [ROWS*2*DATAWIDTH-1:0]   out_vec;
    logic                          sat_flag;

    modport master (
        output in_valid, in_vec, act_mode,
        output wt_we, wt_row, wt_data,
        output bias_we, bias_row, bias_data, bias_accum,
        output out_ready,
        input  in_ready, out_valid, out_vec, sat_flag
    );

    modport slave (
        input  in_valid, in_vec, act_mode,
        input  wt_we, wt_row, wt_data,
        input  bias_we, bias_row, bias_data, bias_accum,
        input  out_ready,
        output in_ready, out_valid, out_vec, sat_flag
    );
endinterface

// File: rtl/dense_layer_tm.sv
// Fully-connected layer y[r] = act(sat(sum_c x[c]*W[r][c] + b[r])) computed by
// LANES shared row-MAC engines, one column per cycle, one row group at a time.
module dense_layer_tm #(
    parameter int ROWS      = 30,
    parameter int COLS      = 64,
    parameter int LANES     = 4,
    parameter int DATAWIDTH = 11
) (
    input  logic            clk,
    input  logic            rst_overall,
    input  logic            clr_vals,
    dense_layer_tm_if.slave io,
    output logic            busy,
    output logic            wr_drop
);
    localparam int DW = DATAWIDTH;
    localparam int PW = 2 * DW;
    localparam int AW = PW + $clog2(COLS);
    localparam int SW = AW + 1;
    localparam int G  = (ROWS + LANES - 1) / LANES;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-PW+1){1'b0}}, {(PW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-PW+1){1'b1}}, {(PW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_OUT} state_t;

    function automatic logic signed [PW-1:0] mul_full(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic sat_hit(input logic signed [SW-1:0] s);
        return (s > SAT_MAX) || (s < SAT_MIN);
    endfunction

    function automatic logic signed [PW-1:0] sat_clamp(input logic signed [SW-1:0] s);
        if (s > SAT_MAX)      return PW'(SAT_MAX);
        else if (s < SAT_MIN) return PW'(SAT_MIN);
        else                  return PW'(s);
    endfunction

    function automatic logic signed [PW-1:0] relu(input logic signed [PW-1:0] v,
                                                  input logic en);
        return (en && v[PW-1]) ? '0 : v;
    endfunction

    function automatic int row_of(input logic [GW-1:0] g, input int l);
        return int'(g) * LANES + l;
    endfunction

    state_t                state_q, state_d;
    logic [GW-1:0]         group_q, group_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  act_q, act_d;
    logic                  sat_int_q, sat_int_d;
    logic                  sat_flag_q, sat_flag_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  wr_drop_q, wr_drop_d;

    logic signed [DW-1:0]  w_q   [ROWS][COLS];
    logic signed [DW-1:0]  w_d   [ROWS][COLS];
    logic signed [PW-1:0]  b_q   [ROWS];
    logic signed [PW-1:0]  b_d   [ROWS];
    logic signed [DW-1:0]  x_q   [COLS];
    logic signed [DW-1:0]  x_d   [COLS];
    logic signed [AW-1:0]  acc_q [LANES];
    logic signed [AW-1:0]  acc_d [LANES];
    logic signed [PW-1:0]  res_q [ROWS];
    logic signed [PW-1:0]  res_d [ROWS];
    logic signed [PW-1:0]  out_q [ROWS];
    logic signed [PW-1:0]  out_d [ROWS];
    logic signed [SW-1:0]  bias_sum;

    always_comb begin
        state_d     = state_q;
        group_d     = group_q;
        col_d       = col_q;
        act_d       = act_q;
        sat_int_d   = sat_int_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = out_valid_q;
        wr_drop_d   = 1'b0;
        w_d         = w_q;
        b_d         = b_q;
        x_d         = x_q;
        acc_d       = acc_q;
        res_d       = res_q;
        out_d       = out_q;
        bias_sum    = '0;

        if (clr_vals) begin
            state_d     = S_IDLE;
            sat_flag_d  = 1'b0;
            out_valid_d = 1'b0;
            for (int l = 0; l < LANES; l++) acc_d[l] = '0;
            for (int r = 0; r < ROWS; r++) out_d[r] = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (io.in_valid && in_ready_q) begin
                        for (int c = 0; c < COLS; c++)
                            x_d[c] = $signed(io.in_vec[(COLS-1-c)*DW +: DW]);
                        for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                        act_d     = io.act_mode;
                        sat_int_d = 1'b0;
                        group_d   = '0;
                        col_d     = '0;
                        state_d   = S_MAC;
                    end
                end
                S_MAC: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (row_of(group_q, l) < ROWS)
                            acc_d[l] = acc_q[l]
                                     + AW'(mul_full(x_q[col_q], w_q[RW'(row_of(group_q, l))][col_q]));
                    end
                    if (col_q == CW'(COLS - 1)) state_d = S_BIAS;
                    else                        col_d   = col_q + CW'(1);
                end
                S_BIAS: begin
                    // Lanes past the last row in a ragged final group fall through untouched.
                    for (int l = 0; l < LANES; l++) begin
                        if (row_of(group_q, l) < ROWS) begin
                            bias_sum = SW'(acc_q[l]) + SW'(b_q[RW'(row_of(group_q, l))]);
                            res_d[RW'(row_of(group_q, l))] = relu(sat_clamp(bias_sum), act_q);
                            if (sat_hit(bias_sum)) sat_int_d = 1'b1;
                        end
                    end
                    if (int'(group_q) < G - 1) begin
                        group_d = group_q + GW'(1);
                        col_d   = '0;
                        for (int l = 0; l < LANES; l++) acc_d[l] = '0;
                        state_d = S_MAC;
                    end else begin
                        // Publish using the buffer as it will be after this edge.
                        out_d       = res_d;
                        sat_flag_d  = sat_int_d;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
                S_OUT: begin
                    if (io.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (!busy_q) begin
                if (io.wt_we && (int'(io.wt_row) < ROWS)) begin
                    for (int c = 0; c < COLS; c++)
                        w_d[io.wt_row][c] = $signed(io.wt_data[(COLS-1-c)*DW +: DW]);
                end
                if (io.bias_we && (int'(io.bias_row) < ROWS)) begin
                    if (io.bias_accum) b_d[io.bias_row] = b_q[io.bias_row] + $signed(io.bias_data);
                    else               b_d[io.bias_row] = $signed(io.bias_data);
                end
            end
        end

        if ((io.wt_we || io.bias_we) && (busy_q || clr_vals)) wr_drop_d = 1'b1;

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_MAC) || (state_d == S_BIAS);
    end

    always_ff @(posedge clk or posedge rst_overall) begin
        if (rst_overall) begin
            state_q     <= S_IDLE;
            group_q     <= '0;
            col_q       <= '0;
            act_q       <= 1'b0;
            sat_int_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                b_q[r]   <= '0;
                res_q[r] <= '0;
                out_q[r] <= '0;
                for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
            end
            for (int c = 0; c < COLS; c++)  x_q[c]   <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            state_q     <= state_d;
            group_q     <= group_d;
            col_q       <= col_d;
            act_q       <= act_d;
            sat_int_q   <= sat_int_d;
            sat_flag_q  <= sat_flag_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            wr_drop_q   <= wr_drop_d;
            w_q         <= w_d;
            b_q         <= b_d;
            x_q         <= x_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            out_q       <= out_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign io.out_vec[(ROWS-1-r)*PW +: PW] = out_q[r];
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.sat_flag  = sat_flag_q;
    assign busy         = busy_q;
    assign wr_drop      = wr_drop_q;
endmodule

// File: tb/tb_dense_layer_tm.sv
// Bench for dense_layer_tm: directed corner cases plus randomized vectors
// checked against a plain-arithmetic model of the layer.
module tb_dense_layer_tm;
    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int LANES = 2;
    localparam int DW    = 11;
    localparam int PW    = 2 * DW;
    localparam int G     = (ROWS + LANES - 1) / LANES;
    localparam int LAT   = G * (COLS + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic clk = 1'b0;
    logic rst_overall = 1'b1;
    logic clr_vals = 1'b0;
    logic busy, wr_drop;

    dense_layer_tm_if #(.ROWS(ROWS), .COLS(COLS), .DATAWIDTH(DW)) bus();

    dense_layer_tm #(.ROWS(ROWS), .COLS(COLS), .LANES(LANES), .DATAWIDTH(DW)) dut (
        .clk         (clk),
        .rst_overall (rst_overall),
        .clr_vals    (clr_vals),
        .io          (bus),
        .busy        (busy),
        .wr_drop     (wr_drop)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint w_m [ROWS][COLS];
    longint b_m [ROWS];
    longint x_m [COLS];
    longint wv  [COLS];
    longint exp_m [ROWS];
    bit     exp_sat;

    task automatic chk(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrap_pw(input longint v);
        logic [PW-1:0] t;
        t = PW'(v);
        return longint'($signed(t));
    endfunction

    function automatic longint rand_dw();
        return longint'($urandom_range(0, (1 << DW) - 1)) - (longint'(1) << (DW - 1));
    endfunction

    function automatic longint rand_pw();
        return longint'($urandom_range(0, (1 << PW) - 1)) - (longint'(1) << (PW - 1));
    endfunction

    function automatic longint rd_row(input int r);
        logic [PW-1:0] t;
        t = bus.out_vec[(ROWS-1-r)*PW +: PW];
        return longint'($signed(t));
    endfunction

    // Reference: exact dot product plus bias, then clamp, then optional ReLU.
    task automatic model_calc(input bit act);
        longint hi, lo, s;
        hi = (longint'(1) <<< (PW - 1)) - 1;
        lo = -(longint'(1) <<< (PW - 1));
        exp_sat = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            s = b_m[r];
            for (int c = 0; c < COLS; c++) s += x_m[c] * w_m[r][c];
            if (s > hi) begin s = hi; exp_sat = 1'b1; end
            else if (s < lo) begin s = lo; exp_sat = 1'b1; end
            if (act && s < 0) s = 0;
            exp_m[r] = s;
        end
    endtask

    task automatic set_x();
        logic [COLS*DW-1:0] v;
        for (int c = 0; c < COLS; c++) v[(COLS-1-c)*DW +: DW] = DW'(x_m[c]);
        bus.in_vec = v;
    endtask

    task automatic pack_wv();
        logic [COLS*DW-1:0] v;
        for (int c = 0; c < COLS; c++) v[(COLS-1-c)*DW +: DW] = DW'(wv[c]);
        bus.wt_data = v;
    endtask

    task automatic wr_w(input int r);
        pack_wv();
        bus.wt_row = RW'(r);
        bus.wt_we  = 1'b1;
        tick();
        bus.wt_we  = 1'b0;
        chk("wr_w.drop", longint'(wr_drop), 0);
        if (r < ROWS) for (int c = 0; c < COLS; c++) w_m[r][c] = wv[c];
    endtask

    task automatic wr_both(input int r, input int br, input longint bv, input bit acc);
        pack_wv();
        bus.wt_row     = RW'(r);
        bus.bias_row   = RW'(br);
        bus.bias_data  = PW'(bv);
        bus.bias_accum = acc;
        bus.wt_we      = 1'b1;
        bus.bias_we    = 1'b1;
        tick();
        bus.wt_we      = 1'b0;
        bus.bias_we    = 1'b0;
        if (r < ROWS) for (int c = 0; c < COLS; c++) w_m[r][c] = wv[c];
        if (br < ROWS) b_m[br] = wrap_pw(acc ? b_m[br] + bv : bv);
    endtask

    task automatic wr_b(input int r, input longint v, input bit acc);
        bus.bias_row   = RW'(r);
        bus.bias_data  = PW'(v);
        bus.bias_accum = acc;
        bus.bias_we    = 1'b1;
        tick();
        bus.bias_we    = 1'b0;
        if (r < ROWS) b_m[r] = wrap_pw(acc ? b_m[r] + v : v);
    endtask

    task automatic set_all_w(input longint v);
        for (int c = 0; c < COLS; c++) wv[c] = v;
        for (int r = 0; r < ROWS; r++) wr_w(r);
    endtask

    task automatic accept(input bit act, input string tag);
        set_x();
        bus.act_mode = act;
        model_calc(act);
        chk({tag, ".in_ready"}, longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.act_mode = ~act;
    endtask

    task automatic wait_out(input string tag, input int want);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, want);
    endtask

    task automatic check_result(input string tag);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("%s.row%0d", tag, r), rd_row(r), exp_m[r]);
        chk({tag, ".sat"}, longint'(bus.sat_flag), longint'(exp_sat));
    endtask

    task automatic finish_out(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_clr"}, longint'(bus.out_valid), 0);
        chk({tag, ".in_ready_back"}, longint'(bus.in_ready), 1);
    endtask

    task automatic run(input bit act, input string tag);
        accept(act, tag);
        wait_out(tag, LAT);
        check_result(tag);
        finish_out(tag);
    endtask

    task automatic set_x_ramp();
        for (int c = 0; c < COLS; c++) x_m[c] = c + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_vec = '0; bus.act_mode = 1'b0;
        bus.wt_we = 1'b0; bus.wt_row = '0; bus.wt_data = '0;
        bus.bias_we = 1'b0; bus.bias_row = '0; bus.bias_data = '0; bus.bias_accum = 1'b0;
        bus.out_ready = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            b_m[r] = 0;
            for (int c = 0; c < COLS; c++) w_m[r][c] = 0;
        end

        repeat (3) @(posedge clk);
        #1 rst_overall = 1'b0;
        tick();
        chk("rst.out_valid", longint'(bus.out_valid), 0);
        chk("rst.in_ready", longint'(bus.in_ready), 1);
        chk("rst.busy", longint'(busy), 0);
        chk("rst.sat", longint'(bus.sat_flag), 0);
        chk("rst.wr_drop", longint'(wr_drop), 0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("rst.row%0d", r), rd_row(r), 0);

        set_all_w(1);
        set_x_ramp();
        run(1'b0, "ones");

        wr_b(1, 5, 1'b0);
        wr_b(1, -2, 1'b1);
        run(1'b0, "bias");

        set_all_w(1023);
        for (int c = 0; c < COLS; c++) x_m[c] = 1023;
        run(1'b0, "sat_pos");
        for (int c = 0; c < COLS; c++) x_m[c] = -1024;
        run(1'b0, "sat_neg");

        wr_b(1, 0, 1'b0);
        set_all_w(-1);
        set_x_ramp();
        run(1'b1, "relu");
        run(1'b0, "linear");

        // Backpressure: result held while out_ready stays low.
        accept(1'b0, "bp");
        wait_out("bp", LAT);
        check_result("bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk("bp.hold_valid", longint'(bus.out_valid), 1);
            chk("bp.hold_in_ready", longint'(bus.in_ready), 0);
            check_result("bp.hold");
        end
        finish_out("bp");
        tick();
        chk("bp.not_accepted", longint'(busy), 0);

        // Weight write while busy must be dropped.
        for (int c = 0; c < COLS; c++) x_m[c] = c - 2;
        accept(1'b0, "drop");
        tick();
        tick();
        for (int c = 0; c < COLS; c++) wv[c] = 7;
        pack_wv();
        bus.wt_row = '0;
        bus.wt_we  = 1'b1;
        tick();
        bus.wt_we  = 1'b0;
        chk("drop.pulse", longint'(wr_drop), 1);
        tick();
        chk("drop.pulse_end", longint'(wr_drop), 0);
        wait_out("drop", LAT - 4);
        check_result("drop");
        finish_out("drop");

        // Abort at the third MAC cycle.
        set_x_ramp();
        accept(1'b0, "clr");
        tick();
        tick();
        clr_vals = 1'b1;
        tick();
        clr_vals = 1'b0;
        chk("clr.in_ready", longint'(bus.in_ready), 1);
        chk("clr.out_valid", longint'(bus.out_valid), 0);
        chk("clr.busy", longint'(busy), 0);
        chk("clr.sat", longint'(bus.sat_flag), 0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("clr.row%0d", r), rd_row(r), 0);
        run(1'b0, "after_clr");

        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) wv[c] = rand_dw();
                wr_w(r);
            end
            for (int c = 0; c < COLS; c++) wv[c] = rand_dw();
            wr_w(ROWS + int'($urandom_range(0, (1 << RW) - 1 - ROWS)));
            for (int c = 0; c < COLS; c++) wv[c] = rand_dw();
            wr_both($urandom_range(0, ROWS - 1), $urandom_range(0, ROWS - 1), rand_pw(),
                    1'($urandom_range(0, 1)));
            wr_b($urandom_range(0, ROWS - 1), rand_pw(), 1'($urandom_range(0, 1)));
            for (int c = 0; c < COLS; c++) x_m[c] = rand_dw();
            run(1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of a computation.
        set_x_ramp();
        accept(1'b0, "arst");
        tick();
        tick();
        #2 rst_overall = 1'b1;
        #1;
        chk("arst.busy", longint'(busy), 0);
        chk("arst.out_valid", longint'(bus.out_valid), 0);
        chk("arst.sat", longint'(bus.sat_flag), 0);
        for (int r = 0; r < ROWS; r++) chk($sformatf("arst.row%0d", r), rd_row(r), 0);
        @(posedge clk);
        #1 rst_overall = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            b_m[r] = 0;
            for (int c = 0; c < COLS; c++) w_m[r][c] = 0;
        end
        run(1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dense_layer_tm.md
Name: dense_layer_tm

Overview:
- Time-multiplexed fully-connected layer: y[r] = act(sat(sum_c x[c]*W[r][c] + b[r])).
- LANES row-MAC engines are shared over ROWS/LANES row groups, replacing one PE per weight.
- Adds valid/ready handshakes, selectable ReLU, a saturation flag, and bias write/accumulate.
- Sits between layer stages of the inference datapath. Owns its weight and bias storage, written by the training controller.

Parameters:
- ROWS, 30, output neurons.
- COLS, 64, input features.
- LANES, 4, rows computed in parallel; 1 <= LANES <= ROWS.
- DATAWIDTH, 11, signed input/weight width; outputs are 2*DATAWIDTH.

Ports:
- clk  in  1  clock.
- rst_overall  in  1  asynchronous active-high reset; clears everything including weights/bias.
- clr_vals  in  1  synchronous abort/clear; weights and bias kept.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high only in IDLE.
- in_vec  in  COLS*DATAWIDTH  element c at [(COLS-c-1)*DATAWIDTH +: DATAWIDTH].
- act_mode  in  1  0 = linear, 1 = ReLU; sampled at input accept.
- wt_we  in  1  weight row write strobe.
- wt_row  in  $clog2(ROWS)  row index.
- wt_data  in  COLS*DATAWIDTH  weight row, same packing as in_vec.
- bias_we  in  1  bias write strobe.
- bias_row  in  $clog2(ROWS)  row index.
- bias_data  in  2*DATAWIDTH  signed bias value.
- bias_accum  in  1  1 = add bias_data to stored bias (wrapping), 0 = overwrite.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_vec  out  ROWS*2*DATAWIDTH  row r at [(ROWS-r-1)*2*DATAWIDTH +: 2*DATAWIDTH].
- sat_flag  out  1  any row saturated in the current result; valid with out_valid.
- busy  out  1  state is MAC or BIAS.
- wr_drop  out  1  one-cycle pulse when a weight/bias write is dropped.

Behaviour:
- Reset (rst_overall): state IDLE; all weights, biases, accumulators and out_vec are 0; out_valid=0, sat_flag=0, wr_drop=0, busy=0. Asserting it mid-operation aborts immediately.
- States: IDLE, MAC, BIAS, OUT. G = ceil(ROWS/LANES).
- IDLE: on in_valid&&in_ready, latch in_vec and act_mode, zero accumulators, group=0, col=0, go to MAC.
- MAC: each cycle, lane l works on row r = group*LANES + l; if r < ROWS, acc[l] += x[col]*W[r][col].
  - Product is full 2*DATAWIDTH signed.
  - acc is 2*DATAWIDTH+$clog2(COLS) bits and never overflows.
  - After col==COLS-1, go to BIAS.
- BIAS (1 cycle): for each valid lane, s = acc + b[r] with one extra bit.
  - Clamp s to [-2^(2DW-1), 2^(2DW-1)-1]; any clamp sets the internal sat flag.
  - Then if act_mode=1 and the value is negative, force it to 0.
  - Write the result to the internal result buffer row r.
  - If group < G-1: group++, col=0, clear acc, go to MAC. Otherwise go to OUT.
  - Lanes with r >= ROWS in the last group are ignored.
- OUT entry: copy the result buffer to out_vec and the sat flag to sat_flag; out_valid=1.
  - out_vec and sat_flag stay stable until the next OUT entry.
- OUT exit: on out_valid&&out_ready, out_valid=0 and return to IDLE. in_valid is ignored while in OUT.
- Latency: out_valid rises exactly G*(COLS+1) clock edges after the accept edge. Throughput is one result per G*(COLS+1)+2 cycles minimum.
- Writes:
  - wt_we and bias_we take effect on the clock edge only when busy=0.
  - When busy=1 the write is dropped and wr_drop pulses for one cycle.
  - A row index >= ROWS is ignored silently.
  - wt_we and bias_we in the same cycle are both honored.
- clr_vals: state goes to IDLE and accumulators, out_vec, sat_flag and out_valid clear to 0. Weights and bias are kept. clr_vals has priority over the handshake and over writes in the same cycle.
- Bias accumulate wraps modulo 2^(2DW); it does not saturate.

Test Plan:
(ROWS=3, COLS=4, LANES=2, DATAWIDTH=11, G=2, latency 10)
- All weights 1, bias 0, x=[1,2,3,4], act_mode=0 -> out_vec rows all 10; out_valid exactly 10 edges after accept; sat_flag=0.
- Bias row1: write 5 with accum=0, then -2 with accum=1; same input -> row1=13, rows 0 and 2=10.
- All weights 1023, x all 1023 -> every row 2097151, sat_flag=1. Weights 1023, x all -1024 -> every row -2097152, sat_flag=1.
- Weights -1, x=[1,2,3,4]: act_mode=1 -> all rows 0; act_mode=0 -> all rows -10.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, out_vec stable, in_ready=0, a pulsed in_valid is not accepted; out_ready=1 -> IDLE next edge.
- wt_we during MAC -> wr_drop=1 for one cycle and weights unchanged. clr_vals at the 3rd MAC cycle -> IDLE, in_ready=1 next cycle, out_valid=0; a new input then yields the correct result with the original weights. rst_overall mid-run -> outputs 0 and weights 0.
